// File: rtl/gamepad_tx.sv
`default_nettype none
// ============================================================================
// Module   : gamepad_tx
// Function : Serial gamepad transmitter. Emits a latch pulse followed by 24
//            clock pulses carrying a captured button word, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module gamepad_tx #(
    parameter int HALF_PERIOD = 6,
    parameter int LATCH_WIDTH = 12,
    parameter int GAP         = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] buttons,
    output logic        busy,
    output logic        done,
    output logic        gp_latch,
    output logic        gp_clk,
    output logic        gp_data
);

    localparam int c_TMR_MAX = (HALF_PERIOD > LATCH_WIDTH)
                             ? ((HALF_PERIOD > GAP) ? HALF_PERIOD : GAP)
                             : ((LATCH_WIDTH > GAP) ? LATCH_WIDTH : GAP);
    localparam int c_TW = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [c_TW-1:0] c_HP_END    = c_TW'(HALF_PERIOD - 1);
    localparam logic [c_TW-1:0] c_LATCH_END = c_TW'(LATCH_WIDTH - 1);
    localparam logic [c_TW-1:0] c_GAP_END   = c_TW'(GAP - 1);
    localparam logic [4:0]      c_LAST_BIT  = 5'd23;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LATCH = 3'd1;
    localparam logic [2:0] c_ST_GAP   = 3'd2;
    localparam logic [2:0] c_ST_LOW   = 3'd3;
    localparam logic [2:0] c_ST_HIGH  = 3'd4;

    logic [2:0]      r_state;
    logic [c_TW-1:0] r_timer;
    logic [4:0]      r_bit;
    logic [23:0]     r_sreg;
    logic            r_busy;
    logic            r_done;
    logic            r_latch;
    logic            r_clk;
    logic            r_data;

    logic [2:0]      w_next_state;
    logic [c_TW-1:0] w_next_timer;
    logic [4:0]      w_next_bit;
    logic [23:0]     w_next_sreg;
    logic            w_frame_end;

    // Every phase counts 0..DURATION-1 and restarts the timer on exit.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer + 1'b1;
        w_next_bit   = r_bit;
        w_next_sreg  = r_sreg;
        w_frame_end  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_next_timer = '0;
                if (start) begin
                    w_next_state = c_ST_LATCH;
                    w_next_sreg  = buttons;
                end
            end
            c_ST_LATCH: begin
                if (r_timer == c_LATCH_END) begin
                    w_next_state = c_ST_GAP;
                    w_next_timer = '0;
                end
            end
            c_ST_GAP: begin
                if (r_timer == c_GAP_END) begin
                    w_next_state = c_ST_LOW;
                    w_next_timer = '0;
                    w_next_bit   = '0;
                end
            end
            c_ST_LOW: begin
                if (r_timer == c_HP_END) begin
                    w_next_state = c_ST_HIGH;
                    w_next_timer = '0;
                end
            end
            c_ST_HIGH: begin
                if (r_timer == c_HP_END) begin
                    w_next_timer = '0;
                    w_next_sreg  = {r_sreg[22:0], 1'b0};
                    if (r_bit == c_LAST_BIT) begin
                        w_next_state = c_ST_IDLE;
                        w_frame_end  = 1'b1;
                    end else begin
                        w_next_state = c_ST_LOW;
                        w_next_bit   = r_bit + 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
                w_next_timer = '0;
            end
        endcase
    end

    // Line outputs are decoded from the next state so they are registered
    // and line up exactly with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_timer <= '0;
            r_bit   <= '0;
            r_sreg  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_latch <= 1'b0;
            r_clk   <= 1'b0;
            r_data  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_next_timer;
            r_bit   <= w_next_bit;
            r_sreg  <= w_next_sreg;
            r_busy  <= (w_next_state != c_ST_IDLE);
            r_done  <= w_frame_end;
            r_latch <= (w_next_state == c_ST_LATCH);
            r_clk   <= (w_next_state == c_ST_HIGH);
            r_data  <= (w_next_state != c_ST_IDLE) & w_next_sreg[23];
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign gp_latch = r_latch;
    assign gp_clk   = r_clk;
    assign gp_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_gamepad_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_gamepad_tx
// Function : Table-driven bench for gamepad_tx at default and minimum timing,
//            with a behavioural latch/clock receiver on the default instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gamepad_tx;

    logic        clk;
    logic        rst;
    logic        st  [2];
    logic [23:0] btn [2];
    logic        bz  [2];
    logic        dn  [2];
    logic        gl  [2];
    logic        gc  [2];
    logic        gd  [2];

    int pass_cnt  = 0;
    int check_cnt = 0;
    bit sel       = 1'b0;

    logic m_latch, m_clk, m_data, m_busy, m_done;
    assign m_latch = gl[sel];
    assign m_clk   = gc[sel];
    assign m_data  = gd[sel];
    assign m_busy  = bz[sel];
    assign m_done  = dn[sel];

    gamepad_tx u_dut_def (
        .clk(clk), .rst(rst), .start(st[0]), .buttons(btn[0]),
        .busy(bz[0]), .done(dn[0]), .gp_latch(gl[0]), .gp_clk(gc[0]), .gp_data(gd[0])
    );

    gamepad_tx #(.HALF_PERIOD(1), .LATCH_WIDTH(1), .GAP(1)) u_dut_min (
        .clk(clk), .rst(rst), .start(st[1]), .buttons(btn[1]),
        .busy(bz[1]), .done(dn[1]), .gp_latch(gl[1]), .gp_clk(gc[1]), .gp_data(gd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model: commits the previous frame on a latch rise only when it
    // saw exactly 24 clock rises; data is shifted in at the LSB.
    logic [23:0] rx_buttons = '0;
    logic [23:0] rx_sh      = '0;
    int          rx_cnt     = 0;
    logic        rx_pl      = 1'b0;
    logic        rx_pc      = 1'b0;
    always @(negedge clk) begin
        rx_pl <= gl[0];
        rx_pc <= gc[0];
        if (gl[0] && !rx_pl) begin
            if (rx_cnt == 24) rx_buttons <= rx_sh;
            rx_cnt <= 0;
            rx_sh  <= '0;
        end else if (gc[0] && !rx_pc) begin
            rx_sh  <= {rx_sh[22:0], gd[0]};
            rx_cnt <= rx_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame on instance s and returns in its done cycle.
    task automatic run_frame(input bit s, input logic [23:0] word, input int exp_lat,
                             input int exp_rise, input int exp_per, input int exp_busy,
                             input bit prestarted, input bit hold, input bit disturb);
        int cyc = 1, lat_first = 0, lat_cnt = 0, busy_cnt = 0, rise_cnt = 0;
        int first_rise = 0, last_rise = 0, bad_int = 0, done_cyc = 0, overlap = 0;
        logic [23:0] cap = '0;
        logic pclk = 1'b0;
        logic busy_at_done = 1'b1;
        sel = s;
        if (!prestarted) begin
            btn[s] = word;
            st[s]  = 1'b1;
            tick();
            if (!hold) st[s] = 1'b0;
        end else if (!hold) begin
            st[s] = 1'b0;
        end
        while (done_cyc == 0 && cyc < 1000) begin
            if (m_latch) begin
                lat_cnt++;
                if (lat_first == 0) lat_first = cyc;
            end
            if (m_busy) busy_cnt++;
            if (m_latch && m_clk) overlap++;
            if (m_clk && !pclk) begin
                cap = {cap[22:0], m_data};
                rise_cnt++;
                if (first_rise == 0) first_rise = cyc;
                else if (cyc - last_rise != exp_per) bad_int++;
                last_rise = cyc;
            end
            pclk = m_clk;
            if (m_done) begin
                done_cyc     = cyc;
                busy_at_done = m_busy;
            end else begin
                if (disturb && cyc == 40) begin
                    btn[s] = ~word;
                    if (!hold) st[s] = 1'b1;
                end
                if (disturb && cyc == 41 && !hold) st[s] = 1'b0;
                tick();
                cyc++;
            end
        end
        check("done_seen",     32'(done_cyc != 0), 32'd1);
        check("latch_first",   lat_first,  1);
        check("latch_width",   lat_cnt,    exp_lat);
        check("first_rise",    first_rise, exp_rise);
        check("rise_count",    rise_cnt,   24);
        check("rise_interval", bad_int,    0);
        check("latch_clk_ovl", overlap,    0);
        check("serial_word",   32'(cap),   32'(word));
        check("busy_cycles",   busy_cnt,   exp_busy);
        check("done_cycle",    done_cyc,   exp_busy + 1);
        check("busy_at_done",  32'(busy_at_done), 32'd0);
    endtask

    typedef struct {
        bit          s;
        logic [23:0] word;
        int          lat;
        int          rise;
        int          per;
        int          busy;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b0, 24'hA5C3F0, 12, 25, 12, 306};
        vecs[1] = '{1'b0, 24'h123456, 12, 25, 12, 306};
        vecs[2] = '{1'b0, 24'h000001, 12, 25, 12, 306};
        vecs[3] = '{1'b1, 24'hA5C3F0,  1,  4,  2,  50};
        vecs[4] = '{1'b1, 24'h5A5A5A,  1,  4,  2,  50};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st[i]  = 1'b0;
            btn[i] = '0;
        end
        tick();
        tick();
        check("reset_def", {27'd0, bz[0], dn[0], gl[0], gc[0], gd[0]}, 32'd0);
        check("reset_min", {27'd0, bz[1], dn[1], gl[1], gc[1], gd[1]}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_def", {27'd0, bz[0], dn[0], gl[0], gc[0], gd[0]}, 32'd0);

        for (int i = 0; i < 5; i++)
            run_frame(vecs[i].s, vecs[i].word, vecs[i].lat, vecs[i].rise,
                      vecs[i].per, vecs[i].busy, 1'b0, 1'b0, 1'b0);
        tick();
        check("rx_after_3", 32'(rx_buttons), 32'h123456);

        // start held: frame A, buttons swapped mid-frame, frame B auto-starts
        run_frame(1'b0, 24'h0F0F0F, 12, 25, 12, 306, 1'b0, 1'b1, 1'b1);
        check("rx_hold_a", 32'(rx_buttons), 32'h000001);
        tick();
        check("b2b_latch", {30'd0, m_latch, m_busy}, 32'd3);
        run_frame(1'b0, 24'hF0F0F0, 12, 25, 12, 306, 1'b1, 1'b0, 1'b0);
        tick();
        check("no_requeue", 32'(m_busy), 32'd0);

        // start pulse and buttons change while busy are ignored
        run_frame(1'b0, 24'h3C3C3C, 12, 25, 12, 306, 1'b0, 1'b0, 1'b1);
        tick();
        check("ignored_start", 32'(m_busy), 32'd0);
        check("rx_disturb", 32'(rx_buttons), 32'hF0F0F0);

        // reset at cycle 100 of a frame
        btn[0] = 24'hABCDEF;
        st[0]  = 1'b1;
        tick();
        st[0]  = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        check("pre_abort_busy", 32'(bz[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_lines", {27'd0, bz[0], dn[0], gl[0], gc[0], gd[0]}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_frame(1'b0, 24'hFFFFFF, 12, 25, 12, 306, 1'b0, 1'b0, 1'b0);
        tick();
        check("rx_no_abort", 32'(rx_buttons), 32'h3C3C3C);
        run_frame(1'b0, 24'h000000, 12, 25, 12, 306, 1'b0, 1'b0, 1'b0);
        tick();
        check("rx_after_clean", 32'(rx_buttons), 32'hFFFFFF);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gamepad_tx.md
Name: gamepad_tx

Overview:
- Serial gamepad transmitter: drives the latch/clock/data wire protocol that input_gamepad decodes.
- On request, it captures a 24-bit button word and emits one frame: a latch pulse, then 24 clock pulses carrying the word MSB first.
- Used as a loopback stimulus source and as a host-side driver for gamepad PMOD pins.
- The receiver commits a frame's buttons only on the next frame's latch rising edge, so frames are sent back-to-back.

Parameters:
- HALF_PERIOD, 6: system clocks per gp_clk low phase and per high phase (≥1).
- LATCH_WIDTH, 12: system clocks gp_latch is held high (≥1).
- GAP, 6: system clocks between latch falling and the first gp_clk low phase (≥1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  frame request; sampled only in IDLE
- buttons  input  24  word to send; captured on accepted start
- busy  output  1  high while a frame is in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse on the first IDLE cycle after a frame
- gp_latch  output  1  latch line
- gp_clk  output  1  shift clock line
- gp_data  output  1  serial data line

Behaviour:
- All outputs are registered.
- Reset, async and active-high: state IDLE; busy, done, gp_latch, gp_clk, gp_data all 0; shift register and counters 0.
- Reset mid-frame: lines drop to 0 immediately. The partial frame is abandoned; the downstream receiver discards it (tick count ≠ 24).
- Internal state:
  - 24-bit shift register sreg.
  - 5-bit bit counter.
  - Phase timer sized to the largest of HALF_PERIOD, LATCH_WIDTH and GAP.
- IDLE:
  - gp_latch=0, gp_clk=0, gp_data=0.
  - If start=1: sreg<=buttons, go to LATCH.
  - Start is accepted in the done cycle too. Start while busy is ignored and not queued.
- LATCH:
  - gp_latch=1, gp_clk=0, gp_data=sreg[23].
  - Lasts exactly LATCH_WIDTH cycles. First gp_latch=1 cycle is the cycle after start was sampled.
  - Then go to GAP.
- GAP:
  - gp_latch=0, gp_clk=0, gp_data=sreg[23].
  - Lasts GAP cycles, then go to LOW with bit counter=0.
- LOW (bit i, i=0..23):
  - gp_clk=0, gp_data=sreg[23].
  - Lasts HALF_PERIOD cycles, then go to HIGH.
  - Data is stable for at least HALF_PERIOD cycles before every gp_clk rising edge.
- HIGH:
  - gp_clk=1, gp_data unchanged.
  - Lasts HALF_PERIOD cycles.
  - On exit, sreg shifts left by 1 (zero fill).
  - If bit counter=23: go to IDLE and pulse done.
  - Otherwise: increment bit counter, go to LOW.
- Bit order: buttons[23] is sent first and buttons[0] last. This matches a receiver that shifts its input in at the LSB.
- Timing:
  - Frame length = LATCH_WIDTH + GAP + 48*HALF_PERIOD cycles (306 at defaults).
  - busy is high for exactly that many cycles.
  - All 24 gp_clk rising edges are exactly 2*HALF_PERIOD apart. This satisfies the receiver's 2:1 interval check.
- gp_latch is never high while gp_clk is high or during LOW/HIGH phases.
- Changes on the buttons input after an accepted start do not affect the frame in flight.

Test Plan:
- Reset, then start with buttons=24'hA5C3F0 (defaults): gp_latch high for cycles 1–12. First gp_clk rise at cycle 25. Sampled gp_data at the 24 rises = 1010_0101_1100_0011_1111_0000. done=1 at cycle 307; busy high for cycles 1–306.
- Loopback into input_gamepad: send frame 24'h123456, then a second frame 24'h000001. Receiver buttons becomes 24'h123456 on the second latch rise. A third frame makes it 24'h000001.
- start held high continuously: frames repeat with a done cycle between them, and each new gp_latch rise follows the done cycle by 1. start pulses during busy, and a buttons change during busy, have no effect on the frame in flight.
- Assert rst at cycle 100 of a frame: all outputs 0 the same cycle. After release and a start with 24'hFFFFFF, a full clean frame is sent. Loopback receiver does not commit the aborted frame.
- HALF_PERIOD=1, LATCH_WIDTH=1, GAP=1: frame is 50 cycles, gp_clk toggles every cycle, and data is correct at every rise.
